// File: rtl/i2c_reg_access.sv
// Register read/write sequencer in front of i2c_master: turns one request into the
// address/register/data byte sequence and returns a single response with error code.
module i2c_reg_access #(
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic [7:0] i2c_address,
   output logic       i2c_transfer_start,
   output logic       i2c_transfer_continues,
   output logic [7:0] i2c_data_tx,
   input  logic       i2c_transfer_ready,
   input  logic       i2c_interrupt,
   input  logic       i2c_transaction_complete,
   input  logic       i2c_nack,
   input  logic       i2c_address_err,
   input  logic       i2c_start_err,
   input  logic       i2c_arbitration_err,
   input  logic [7:0] i2c_data_rx,
   output logic [2:0] dbg_state
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_REG    = 3'd2,
      S_WDATA  = 3'd3,
      S_RSTART = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   // Handshakes: req is taken on req_valid && req_ready; rsp is consumed on
   // rsp_valid && rsp_ready, and rsp_valid holds until then.
   state_t        r_state;
   state_t        w_next;
   logic          r_rw;
   logic [6:0]    r_dev;
   logic [7:0]    r_reg;
   logic [7:0]    r_wdata;
   logic [7:0]    r_rdata;
   logic [1:0]    r_err;
   logic [CW-1:0] r_cnt;
   logic [7:0]    w_rdata_next;
   logic [1:0]    w_err_next;
   logic [1:0]    w_err_code;
   logic          w_done_ev;
   logic          w_err_ev;
   logic          w_active;
   logic          w_timeout;

   assign w_done_ev  = i2c_interrupt && i2c_transaction_complete;
   assign w_err_ev   = i2c_interrupt && (i2c_address_err || i2c_arbitration_err || i2c_start_err);
   assign w_err_code = i2c_address_err ? 2'd1 : 2'd3;
   assign w_active   = (r_state == S_START) || (r_state == S_REG) ||
                       (r_state == S_WDATA) || (r_state == S_RSTART);
   assign w_timeout  = w_active && (r_cnt >= TO_LAST);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_rw    <= 1'b0;
         r_dev   <= 7'd0;
         r_reg   <= 8'd0;
         r_wdata <= 8'd0;
         r_rdata <= 8'd0;
         r_err   <= 2'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_rdata <= w_rdata_next;
         r_err   <= w_err_next;
         if (r_state == S_IDLE && req_valid) begin
            r_rw    <= req_rw;
            r_dev   <= req_dev;
            r_reg   <= req_reg;
            r_wdata <= req_wdata;
         end
         if (w_next != r_state)
            r_cnt <= '0;
         else if (w_active && r_cnt != {CW{1'b1}})
            r_cnt <= r_cnt + 1'b1;
      end
   end

   // Error events win over completion; timeout only if nothing else happened.
   always_comb begin
      w_next       = r_state;
      w_rdata_next = r_rdata;
      w_err_next   = r_err;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_next       = S_START;
               w_rdata_next = 8'd0;
               w_err_next   = 2'd0;
            end
         end
         S_START: begin
            if (w_err_ev) begin
               w_next     = S_RESP;
               w_err_next = w_err_code;
            end else if (i2c_transfer_ready) begin
               w_next = S_REG;
            end else if (w_timeout) begin
               w_next     = S_RESP;
               w_err_next = 2'd3;
            end
         end
         S_REG: begin
            if (w_err_ev) begin
               w_next     = S_RESP;
               w_err_next = w_err_code;
            end else if (w_done_ev) begin
               if (i2c_nack) begin
                  w_next     = S_RESP;
                  w_err_next = 2'd2;
               end else begin
                  w_next = r_rw ? S_RSTART : S_WDATA;
               end
            end else if (w_timeout) begin
               w_next     = S_RESP;
               w_err_next = 2'd3;
            end
         end
         S_WDATA: begin
            if (w_err_ev) begin
               w_next     = S_RESP;
               w_err_next = w_err_code;
            end else if (w_done_ev) begin
               w_next     = S_RESP;
               w_err_next = i2c_nack ? 2'd2 : 2'd0;
            end else if (w_timeout) begin
               w_next     = S_RESP;
               w_err_next = 2'd3;
            end
         end
         S_RSTART: begin
            if (w_err_ev) begin
               w_next     = S_RESP;
               w_err_next = w_err_code;
            end else if (w_done_ev) begin
               // The last read byte is always NACKed by the master, so nack is not an error.
               w_next       = S_RESP;
               w_rdata_next = i2c_data_rx;
               w_err_next   = 2'd0;
            end else if (w_timeout) begin
               w_next     = S_RESP;
               w_err_next = 2'd3;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next       = S_IDLE;
               w_rdata_next = 8'd0;
               w_err_next   = 2'd0;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      i2c_address            = 8'd0;
      i2c_transfer_start     = 1'b0;
      i2c_transfer_continues = 1'b0;
      i2c_data_tx            = 8'd0;
      case (r_state)
         S_START: begin
            i2c_address            = {r_dev, 1'b0};
            i2c_transfer_start     = 1'b1;
            i2c_transfer_continues = !r_rw;
            i2c_data_tx            = r_reg;
         end
         S_REG: begin
            i2c_address            = {r_dev, 1'b0};
            i2c_transfer_continues = !r_rw;
            i2c_data_tx            = r_reg;
         end
         S_WDATA: begin
            i2c_address = {r_dev, 1'b0};
            i2c_data_tx = r_wdata;
         end
         S_RSTART: begin
            i2c_address        = {r_dev, 1'b1};
            i2c_transfer_start = 1'b1;
            i2c_data_tx        = r_reg;
         end
         default: ;
      endcase
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign dbg_state = r_state;

endmodule

// File: doc/i2c_reg_access.md
# i2c_reg_access

Register-access sequencer that sits directly upstream of `i2c_master` and drives its transfer handshake. It accepts one register read or write request at a time: a 7-bit device address, an 8-bit register index, and write data if the request is a write. It then issues the I2C byte sequence through the master and returns a single response carrying the read data and an error code. It exists so that configuration FSMs elsewhere in the design never handle `transfer_start`/`transfer_continues` sequencing themselves.

## Interface
- `TIMEOUT_CYCLES`, default 5000000: number of `clk_in` cycles without a completion event before the operation aborts (100 ms at 50 MHz).
- `clk_in`  in  1  system clock; the same clock as `i2c_master`.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_rw`  in  1  1 = read, 0 = write.
- `req_dev`  in  7  7-bit device address.
- `req_reg`  in  8  register index.
- `req_wdata`  in  8  write data; ignored for reads.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  8  read data; 0 for writes and for errors.
- `rsp_err`  out  2  0 = OK, 1 = address NACK, 2 = data NACK, 3 = arbitration/start error or timeout.
- `i2c_address`  out  8  to master `address`, as {dev, mode}.
- `i2c_transfer_start`  out  1  to master `transfer_start`.
- `i2c_transfer_continues`  out  1  to master `transfer_continues`.
- `i2c_data_tx`  out  8  to master `data_tx`.
- `i2c_transfer_ready`, `i2c_interrupt`, `i2c_transaction_complete`, `i2c_nack`, `i2c_address_err`, `i2c_start_err`, `i2c_arbitration_err`  in  1 each  from the master's outputs of the same names.
- `i2c_data_rx`  in  8  from master `data_rx`.

## Operation
- **States:** IDLE, START, REG, WDATA, RSTART, RESP.
- **Event definitions:**
  - `done_ev = i2c_interrupt && i2c_transaction_complete`.
  - `err_ev = i2c_interrupt && (i2c_address_err || i2c_arbitration_err || i2c_start_err)`.
  - `err_ev` has priority over `done_ev` when both occur in the same cycle.
- **IDLE:**
  - `req_ready = 1`.
  - On acceptance, register `rw`, `dev`, `reg` and `wdata`, then go to START.
- **START:**
  - Drive `i2c_address = {dev, 0}`, `i2c_data_tx = reg` and `i2c_transfer_start = 1`.
  - Drive `i2c_transfer_continues = !rw`.
  - Stay in START until the first cycle with `i2c_transfer_ready = 1`, then go to REG.
- **REG:**
  - `i2c_transfer_start = 0`; all other master outputs hold their START values.
  - On `done_ev` with `nack = 1`: `err = 2`, go to RESP.
  - On `done_ev` with `nack = 0`: go to WDATA if writing, RSTART if reading.
- **WDATA:**
  - Drive `i2c_data_tx = wdata` and `i2c_transfer_continues = 0`.
  - On `done_ev`: `err = nack ? 2 : 0`, go to RESP.
- **RSTART (repeated start):**
  - Drive `i2c_address = {dev, 1}`, `i2c_transfer_start = 1` and `i2c_transfer_continues = 0`.
  - On `done_ev`: capture `i2c_data_rx` into `rsp_rdata`, set `err = 0`, go to RESP. The master NACKs the final read byte, so `nack` is ignored here.
- **Errors:**
  - `err_ev` in START, REG, WDATA or RSTART goes to RESP.
  - `err = 1` if `i2c_address_err` is set, else `err = 3`.
- **Timeout:**
  - The timeout counter clears on every state change and counts in START, REG, WDATA and RSTART.
  - Reaching `TIMEOUT_CYCLES-1` forces `err = 3` and goes to RESP.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`; the counter saturates and never wraps.
- **RESP:**
  - All `i2c_*` outputs are 0; `rsp_valid = 1`.
  - On `rsp_ready`, go to IDLE.
  - `rsp_rdata` is 0 unless a read completed with `err = 0`.

## Timing
- **Reset values:**
  - `req_ready = 1` (state IDLE).
  - `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`.
  - All `i2c_*` outputs 0; counter 0.
- All outputs are registered, or decoded only from registered state.
- An accepted request drives `i2c_transfer_start` in the next cycle.
- `rsp_valid` rises one cycle after the terminating event.
- `req_ready` is 0 from the acceptance cycle until the cycle after the RESP handshake. Minimum spacing between accepts is 1 cycle after the response is consumed.
- `req_*` changes after acceptance have no effect.
- **Reset mid-operation:**
  - Outputs go to reset values immediately and asynchronously.
  - This block does not reset the master. The bus is recovered by the master's own `bus_clear`.
- The `i2c_*` outputs stay stable throughout each wait state; the master may sample them on any cycle.

## Test plan
- Write dev 0x3C, reg 0x10, data 0xA5, slave ACKs all bytes -> the master sees address 0x78, `data_tx` 0x10 then 0xA5, continues 1 then 0; response `err = 0`, `rdata = 0x00`.
- Read dev 0x50, reg 0x02, slave returns 0x7E -> address 0xA0 then 0xA1 with the RSTART `transfer_start` pulse; response `err = 0`, `rdata = 0x7E`.
- Write to an absent dev 0x11 -> `address_err` with interrupt; response `err = 1`, no further `transfer_start` issued.
- Write where the slave NACKs the data byte 0xFF -> response `err = 2`; the next request is accepted afterwards.
- `TIMEOUT_CYCLES = 100`, master never interrupts -> `rsp_valid` rises in cycle 101 after START with `err = 3`, all `i2c_*` outputs 0.
- Assert `reset` during REG of a write -> `i2c_transfer_start`/`continues` drop to 0 the same cycle and `req_ready = 1`; the following read completes normally.
